// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared definitions for the EtherNeco sync-timer master sequencer and the slave nodes.
// Holds the round state, the frame geometry and the common time/count types.
package jellyvl_etherneco_synctimer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_SEND = 2'd1,
    STATE_WAIT = 2'd2
  } t_state;

  // Sync frame: one sequence byte followed by an 8-byte timestamp, LSB first
  localparam int          FRAME_LENGTH       = 9;
  localparam logic [3:0]  FRAME_LAST_INDEX   = 4'(FRAME_LENGTH - 1);
  localparam logic [7:0]  FRAME_TYPE_DEFAULT = 8'h10;

  typedef logic [63:0] t_time;
  typedef logic [15:0] t_count;

endpackage

// File: rtl/jellyvl_etherneco_synctimer_period_gen.sv
// Free-running sync period counter; produces a one-cycle registered tick every param_period cycles.
// Lowering param_period below the running count restarts the period without a tick.
module jellyvl_etherneco_synctimer_period_gen
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] param_period,
  output logic                    tick
);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] count_last;

  assign count_last = param_period - PERIOD_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable || param_period == '0) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == count_last) begin
      count <= '0;
      tick  <= 1'b1;
    end else if (count > count_last) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count + PERIOD_WIDTH'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_sequencer.sv
// Master-side sync round sequencer: latches the local time on each period tick, streams the
// 9-byte sync frame to the ring command transmitter and classifies the returning response.
module jellyvl_etherneco_synctimer_sequencer
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int                     TIMER_WIDTH   = 64,
  parameter int                     PERIOD_WIDTH  = 32,
  parameter int                     TIMEOUT_WIDTH = 24,
  parameter int                     COUNT_WIDTH   = 16,
  parameter logic [7:0]             FRAME_TYPE    = FRAME_TYPE_DEFAULT,
  parameter logic [TIMER_WIDTH-1:0] TIME_OFFSET   = '0
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     enable,
  input  logic [PERIOD_WIDTH-1:0]  param_period,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  output logic [7:0]               cmd_tx_type,
  output logic [15:0]              cmd_tx_length,
  output logic                     m_cmd_first,
  output logic                     m_cmd_last,
  output logic [7:0]               m_cmd_data,
  output logic                     m_cmd_valid,
  input  logic                     m_cmd_ready,
  input  logic                     res_rx_end,
  input  logic                     res_rx_error,
  output logic                     busy,
  output logic [7:0]               seq_no,
  output logic [COUNT_WIDTH-1:0]   sync_count,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic [COUNT_WIDTH-1:0]   timeout_count,
  output logic [COUNT_WIDTH-1:0]   overrun_count
);

  localparam int TW1 = TIMEOUT_WIDTH + 1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] seq, input t_time t,
                                            input logic [3:0] index);
    logic [7:0] b;
    case (index)
      4'd1:    b = t[7:0];
      4'd2:    b = t[15:8];
      4'd3:    b = t[23:16];
      4'd4:    b = t[31:24];
      4'd5:    b = t[39:32];
      4'd6:    b = t[47:40];
      4'd7:    b = t[55:48];
      4'd8:    b = t[63:56];
      default: b = seq;
    endcase
    return b;
  endfunction

  logic tick;

  jellyvl_etherneco_synctimer_period_gen #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_period_gen (
    .reset       (reset),
    .clk         (clk),
    .enable      (enable),
    .param_period(param_period),
    .tick        (tick)
  );

  t_state                   state, state_next;
  logic [3:0]               index, index_next;
  t_time                    time_latch, time_latch_next;
  logic [TIMEOUT_WIDTH-1:0] wait_count, wait_count_next;
  logic [TW1-1:0]           wait_elapsed;
  logic [7:0]               seq_no_next, data_next;
  logic                     valid_next, first_next, last_next;
  logic [COUNT_WIDTH-1:0]   sync_next, error_next, timeout_next, overrun_next;

  // Elapsed WAIT cycles including the current one; 0 and 1 both expire on the first cycle
  assign wait_elapsed  = {1'b0, wait_count} + TW1'(1);

  assign busy          = (state != STATE_IDLE);
  assign cmd_tx_type   = busy ? FRAME_TYPE : 8'h00;
  assign cmd_tx_length = busy ? 16'(FRAME_LENGTH) : 16'h0000;

  always_comb begin
    state_next      = state;
    index_next      = index;
    time_latch_next = time_latch;
    wait_count_next = wait_count;
    seq_no_next     = seq_no;
    data_next       = m_cmd_data;
    valid_next      = m_cmd_valid;
    first_next      = m_cmd_first;
    last_next       = m_cmd_last;
    sync_next       = sync_count;
    error_next      = error_count;
    timeout_next    = timeout_count;
    overrun_next    = overrun_count;

    if (tick && state != STATE_IDLE) begin
      overrun_next = sat_inc(overrun_count);
    end

    case (state)
      STATE_IDLE: begin
        if (tick) begin
          seq_no_next     = seq_no + 8'd1;
          time_latch_next = current_time + TIME_OFFSET;
          index_next      = 4'd0;
          data_next       = seq_no + 8'd1;
          valid_next      = 1'b1;
          first_next      = 1'b1;
          last_next       = 1'b0;
          state_next      = STATE_SEND;
        end
      end
      STATE_SEND: begin
        if (m_cmd_valid && m_cmd_ready) begin
          if (index == FRAME_LAST_INDEX) begin
            valid_next      = 1'b0;
            first_next      = 1'b0;
            last_next       = 1'b0;
            wait_count_next = '0;
            state_next      = STATE_WAIT;
          end else begin
            index_next = index + 4'd1;
            data_next  = frame_byte(seq_no, time_latch, index + 4'd1);
            first_next = 1'b0;
            last_next  = (index + 4'd1 == FRAME_LAST_INDEX);
          end
        end
      end
      STATE_WAIT: begin
        // A response arriving on the expiry cycle still counts as a response
        if (res_rx_end) begin
          if (res_rx_error) begin
            error_next = sat_inc(error_count);
          end else begin
            sync_next = sat_inc(sync_count);
          end
          state_next = STATE_IDLE;
        end else if (wait_elapsed >= {1'b0, param_timeout}) begin
          timeout_next = sat_inc(timeout_count);
          state_next   = STATE_IDLE;
        end else begin
          wait_count_next = wait_count + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_next = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= STATE_IDLE;
      index         <= 4'd0;
      wait_count    <= '0;
      seq_no        <= 8'h00;
      m_cmd_data    <= 8'h00;
      m_cmd_valid   <= 1'b0;
      m_cmd_first   <= 1'b0;
      m_cmd_last    <= 1'b0;
      sync_count    <= '0;
      error_count   <= '0;
      timeout_count <= '0;
      overrun_count <= '0;
    end else begin
      state         <= state_next;
      index         <= index_next;
      wait_count    <= wait_count_next;
      seq_no        <= seq_no_next;
      m_cmd_data    <= data_next;
      m_cmd_valid   <= valid_next;
      m_cmd_first   <= first_next;
      m_cmd_last    <= last_next;
      sync_count    <= sync_next;
      error_count   <= error_next;
      timeout_count <= timeout_next;
      overrun_count <= overrun_next;
    end
  end

  always_ff @(posedge clk) begin
    time_latch <= time_latch_next;
  end

endmodule
